// File: rtl/memtrace_pkg.sv
// Shared widths, payload structs and serializer state encoding for the memory trace recorder.
package memtrace_pkg;

   localparam int unsigned NUM_LANES     = 4;
   localparam int unsigned DATA_WIDTH    = 64;
   localparam int unsigned LOGSIZE_WIDTH = 8;
   localparam int unsigned CYCLE_WIDTH   = 64;
   localparam int unsigned DEPTH         = 4;
   localparam int unsigned LANE_ID_WIDTH = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

   typedef struct packed {
      logic [DATA_WIDTH-1:0]    address;
      logic                     is_store;
      logic [LOGSIZE_WIDTH-1:0] size;
      logic [DATA_WIDTH-1:0]    data;
   } memtrace_lane_t;

   typedef struct packed {
      logic [CYCLE_WIDTH-1:0]         cycle;
      logic [NUM_LANES-1:0]           mask;
      memtrace_lane_t [NUM_LANES-1:0] lane;
   } memtrace_snapshot_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      DONE = 2'd2
   } memtrace_state_e;

   // Index of the lowest set bit; zero when the mask is empty.
   function automatic logic [LANE_ID_WIDTH-1:0] lowest_lane(input logic [NUM_LANES-1:0] mask);
      logic [LANE_ID_WIDTH-1:0] sel;
      sel = '0;
      for (int i = int'(NUM_LANES) - 1; i >= 0; i--) begin
         if (mask[i]) sel = LANE_ID_WIDTH'(i);
      end
      return sel;
   endfunction

endpackage

// File: rtl/memtrace_if.sv
// Snapshot capture and record stream bundle between a trace source/sink and the recorder.
interface memtrace_if;
   import memtrace_pkg::*;

   logic [CYCLE_WIDTH-1:0]             in_cycle;
   logic [NUM_LANES-1:0]               in_valid;
   logic [DATA_WIDTH*NUM_LANES-1:0]    in_address;
   logic [NUM_LANES-1:0]               in_is_store;
   logic [LOGSIZE_WIDTH*NUM_LANES-1:0] in_size;
   logic [DATA_WIDTH*NUM_LANES-1:0]    in_data;
   logic                               in_finished;
   logic                               in_ready;

   logic                               out_valid;
   logic                               out_ready;
   logic [CYCLE_WIDTH-1:0]             out_cycle;
   logic [LANE_ID_WIDTH-1:0]           out_lane_id;
   logic [DATA_WIDTH-1:0]              out_address;
   logic                               out_is_store;
   logic [LOGSIZE_WIDTH-1:0]           out_size;
   logic [DATA_WIDTH-1:0]              out_data;
   logic                               done;

   modport master (
      output in_cycle, in_valid, in_address, in_is_store, in_size, in_data, in_finished, out_ready,
      input  in_ready, out_valid, out_cycle, out_lane_id, out_address, out_is_store, out_size,
             out_data, done
   );

   modport slave (
      input  in_cycle, in_valid, in_address, in_is_store, in_size, in_data, in_finished, out_ready,
      output in_ready, out_valid, out_cycle, out_lane_id, out_address, out_is_store, out_size,
             out_data, done
   );

endinterface

// File: rtl/memtrace_snapshot_fifo.sv
// Snapshot FIFO with wrap-bit pointers; exposes the head and fullness as they will be after this edge.
module memtrace_snapshot_fifo
   import memtrace_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = DEPTH
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               i_push,
   input  logic               i_pop,
   input  memtrace_snapshot_t i_data,
   output memtrace_snapshot_t o_head_next_c,
   output logic               o_full_next_c,
   output logic               o_empty_next_c
);

   localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;

   memtrace_snapshot_t r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   w_rd_ptr_next;
   logic [PTR_W-1:0]   w_wr_ptr_next;
   logic               w_full;
   logic               w_empty;
   logic               w_push;
   logic               w_pop;

   assign w_full  = (r_rd_ptr[IDX_W] != r_wr_ptr[IDX_W]) &&
                    (r_rd_ptr[IDX_W-1:0] == r_wr_ptr[IDX_W-1:0]);
   assign w_empty = (r_rd_ptr == r_wr_ptr);
   assign w_push  = i_push && !w_full;
   assign w_pop   = i_pop && !w_empty;

   assign w_wr_ptr_next = r_wr_ptr + PTR_W'(w_push);
   assign w_rd_ptr_next = r_rd_ptr + PTR_W'(w_pop);

   assign o_empty_next_c = (w_rd_ptr_next == w_wr_ptr_next);
   assign o_full_next_c  = (w_rd_ptr_next[IDX_W] != w_wr_ptr_next[IDX_W]) &&
                           (w_rd_ptr_next[IDX_W-1:0] == w_wr_ptr_next[IDX_W-1:0]);

   // A push landing in the slot that becomes head is forwarded straight through.
   assign o_head_next_c = (w_push && (w_rd_ptr_next == r_wr_ptr)) ? i_data
                                                                  : r_mem[w_rd_ptr_next[IDX_W-1:0]];

   always_ff @(posedge clock) begin
      if (reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
      end else begin
         r_rd_ptr <= w_rd_ptr_next;
         r_wr_ptr <= w_wr_ptr_next;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && w_push) r_mem[r_wr_ptr[IDX_W-1:0]] <= i_data;
   end

endmodule

// File: rtl/memtrace_recorder.sv
// Captures per-cycle lane snapshots and serializes them into one record per valid lane, lowest lane first.
module memtrace_recorder
   import memtrace_pkg::*;
(
   input logic       clock,
   input logic       reset,
   memtrace_if.slave bus
);

   memtrace_state_e          r_state;
   logic [NUM_LANES-1:0]     r_pend;
   logic                     r_fin;
   logic                     r_in_ready;
   logic                     r_out_valid;
   logic                     r_done;
   logic [CYCLE_WIDTH-1:0]   r_out_cycle;
   logic [LANE_ID_WIDTH-1:0] r_out_lane_id;
   memtrace_lane_t           r_out_lane;

   memtrace_snapshot_t       w_push_data;
   memtrace_snapshot_t       w_head_next;
   logic                     w_push;
   logic                     w_hs;
   logic                     w_last;
   logic                     w_fin_next;
   logic                     w_full_next;
   logic                     w_empty_next;
   logic [NUM_LANES-1:0]     w_pend_clr;
   logic [NUM_LANES-1:0]     w_pend_next;
   logic [LANE_ID_WIDTH-1:0] w_sel;

   always_comb begin
      w_push_data       = '0;
      w_push_data.cycle = bus.in_cycle;
      w_push_data.mask  = bus.in_valid;
      for (int g = 0; g < int'(NUM_LANES); g++) begin
         w_push_data.lane[g].address  = bus.in_address[g*DATA_WIDTH +: DATA_WIDTH];
         w_push_data.lane[g].is_store = bus.in_is_store[g];
         w_push_data.lane[g].size     = bus.in_size[g*LOGSIZE_WIDTH +: LOGSIZE_WIDTH];
         w_push_data.lane[g].data     = bus.in_data[g*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign w_push     = r_in_ready && (|bus.in_valid);
   assign w_hs       = r_out_valid && bus.out_ready;
   assign w_pend_clr = r_pend & ~(NUM_LANES'(1) << r_out_lane_id);
   assign w_last     = w_hs && (w_pend_clr == '0);
   assign w_fin_next = r_fin || bus.in_finished;

   memtrace_snapshot_fifo #(
      .FIFO_DEPTH (DEPTH)
   ) u_fifo (
      .clock          (clock),
      .reset          (reset),
      .i_push         (w_push),
      .i_pop          (w_last),
      .i_data         (w_push_data),
      .o_head_next_c  (w_head_next),
      .o_full_next_c  (w_full_next),
      .o_empty_next_c (w_empty_next)
   );

   // Pending lanes of whichever entry will be head after this edge.
   always_comb begin
      w_pend_next = r_pend;
      if (w_empty_next) begin
         w_pend_next = '0;
      end else if (w_hs && !w_last) begin
         w_pend_next = w_pend_clr;
      end else if (w_last || (r_pend == '0)) begin
         w_pend_next = w_head_next.mask;
      end
   end

   assign w_sel = lowest_lane(w_pend_next);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= IDLE;
         r_pend        <= '0;
         r_fin         <= 1'b0;
         r_in_ready    <= 1'b1;
         r_out_valid   <= 1'b0;
         r_done        <= 1'b0;
         r_out_cycle   <= '0;
         r_out_lane_id <= '0;
         r_out_lane    <= '0;
      end else begin
         r_pend     <= w_pend_next;
         r_fin      <= w_fin_next;
         r_in_ready <= !w_full_next && !w_fin_next;

         // Record fields are preloaded so they are valid the cycle the head appears.
         if (w_empty_next) begin
            r_out_cycle   <= '0;
            r_out_lane_id <= '0;
            r_out_lane    <= '0;
         end else begin
            r_out_cycle   <= w_head_next.cycle;
            r_out_lane_id <= w_sel;
            r_out_lane    <= w_head_next.lane[w_sel];
         end

         case (r_state)
            IDLE: begin
               if (w_push) begin
                  r_state     <= EMIT;
                  r_out_valid <= 1'b1;
               end else if (r_fin) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
               end
            end
            EMIT: begin
               if (w_last && w_empty_next) begin
                  r_state     <= r_fin ? DONE : IDLE;
                  r_out_valid <= 1'b0;
                  r_done      <= r_fin;
               end
            end
            DONE: begin
               r_state <= DONE;
            end
            default: begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
               r_done      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready     = r_in_ready;
   assign bus.out_valid    = r_out_valid;
   assign bus.out_cycle    = r_out_cycle;
   assign bus.out_lane_id  = r_out_lane_id;
   assign bus.out_address  = r_out_lane.address;
   assign bus.out_is_store = r_out_lane.is_store;
   assign bus.out_size     = r_out_lane.size;
   assign bus.out_data     = r_out_lane.data;
   assign bus.done         = r_done;

endmodule

// File: tb/tb_memtrace_recorder.sv
// Scoreboard bench for memtrace_recorder: a queue-level reference model predicts records, in_ready and done.
module tb_memtrace_recorder;
   import memtrace_pkg::*;

   typedef struct {
      logic [CYCLE_WIDTH-1:0]   cycle;
      logic [LANE_ID_WIDTH-1:0] lane;
      logic [DATA_WIDTH-1:0]    address;
      logic                     is_store;
      logic [LOGSIZE_WIDTH-1:0] size;
      logic [DATA_WIDTH-1:0]    data;
   } rec_t;

   logic clock = 1'b0;
   logic reset;

   memtrace_if bus ();

   memtrace_recorder dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   rec_t sb_q[$];
   int   snap_q[$];
   logic m_fin    = 1'b0;
   logic m_done   = 1'b0;
   logic m_live   = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: FIFO of snapshots as lane counts, records listed in emission order.
   always @(posedge clock) begin : model
      logic old_fin;
      logic accept;
      int   k;
      rec_t r;
      if (reset) begin
         sb_q.delete();
         snap_q.delete();
         m_fin  = 1'b0;
         m_done = 1'b0;
         m_live = 1'b1;
      end else if (m_live) begin
         old_fin = m_fin;
         accept  = (snap_q.size() < int'(DEPTH)) && !old_fin && (bus.in_valid != '0);
         if (snap_q.size() > 0 && bus.out_ready) begin
            snap_q[0] = snap_q[0] - 1;
            if (snap_q[0] == 0) void'(snap_q.pop_front());
         end
         if (accept) begin
            k = 0;
            for (int g = 0; g < int'(NUM_LANES); g++) begin
               if (bus.in_valid[g]) begin
                  r.cycle    = bus.in_cycle;
                  r.lane     = LANE_ID_WIDTH'(g);
                  r.address  = bus.in_address[g*DATA_WIDTH +: DATA_WIDTH];
                  r.is_store = bus.in_is_store[g];
                  r.size     = bus.in_size[g*LOGSIZE_WIDTH +: LOGSIZE_WIDTH];
                  r.data     = bus.in_data[g*DATA_WIDTH +: DATA_WIDTH];
                  sb_q.push_back(r);
                  k++;
               end
            end
            snap_q.push_back(k);
         end
         m_fin  = old_fin || bus.in_finished;
         m_done = m_done || (old_fin && snap_q.size() == 0);
      end
   end

   // Monitor: compare DUT outputs away from the active edge.
   always @(negedge clock) begin : monitor
      rec_t e;
      if (m_live) begin
         check("in_ready", 64'(bus.in_ready), 64'((snap_q.size() < int'(DEPTH)) && !m_fin));
         check("done", 64'(bus.done), 64'(m_done));
         check("out_valid", 64'(bus.out_valid), 64'(snap_q.size() != 0));
         if (bus.out_valid) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL extra_record: got lane %0d cycle %0d expected no record at %0t",
                        bus.out_lane_id, bus.out_cycle, $time);
            end else begin
               e = sb_q[0];
               check("rec_cycle", bus.out_cycle, e.cycle);
               check("rec_lane", 64'(bus.out_lane_id), 64'(e.lane));
               check("rec_address", bus.out_address, e.address);
               check("rec_is_store", 64'(bus.out_is_store), 64'(e.is_store));
               check("rec_size", 64'(bus.out_size), 64'(e.size));
               check("rec_data", bus.out_data, e.data);
               if (bus.out_ready) void'(sb_q.pop_front());
            end
         end else begin
            check("idle_cycle", bus.out_cycle, 64'd0);
            check("idle_lane", 64'(bus.out_lane_id), 64'd0);
            check("idle_address", bus.out_address, 64'd0);
            check("idle_data", bus.out_data, 64'd0);
            check("idle_size_store", 64'({bus.out_size, bus.out_is_store}), 64'd0);
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      bus.in_valid    = '0;
      bus.in_finished = 1'b0;
   endtask

   task automatic set_snapshot(input logic [NUM_LANES-1:0] mask, input logic [63:0] cyc);
      bus.in_valid = mask;
      bus.in_cycle = cyc;
      for (int g = 0; g < int'(NUM_LANES); g++) begin
         bus.in_address[g*DATA_WIDTH +: DATA_WIDTH]        = {$urandom, $urandom};
         bus.in_data[g*DATA_WIDTH +: DATA_WIDTH]           = {$urandom, $urandom};
         bus.in_size[g*LOGSIZE_WIDTH +: LOGSIZE_WIDTH]     = LOGSIZE_WIDTH'($urandom_range(0, 3));
         bus.in_is_store[g]                                = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic random_phase(input int cycles, input int fin_at);
      logic [63:0] cyc;
      cyc = 64'd1000;
      for (int i = 0; i < cycles; i++) begin
         if ($urandom_range(0, 3) == 0) bus.in_valid = '0;
         else set_snapshot(NUM_LANES'($urandom), cyc);
         bus.in_finished = (i == fin_at);
         bus.out_ready   = ($urandom_range(0, 9) < 7);
         cyc             = cyc + 64'd1;
         step();
      end
      idle_inputs();
      bus.out_ready = 1'b1;
      repeat (30) step();
   endtask

   initial begin
      reset           = 1'b1;
      bus.in_cycle    = '0;
      bus.in_address  = '0;
      bus.in_is_store = '0;
      bus.in_size     = '0;
      bus.in_data     = '0;
      bus.out_ready   = 1'b0;
      idle_inputs();
      repeat (2) step();
      reset = 1'b0;
      step();

      // Single snapshot, lanes 1 and 3.
      bus.out_ready = 1'b1;
      set_snapshot(4'b1010, 64'd100);
      step();
      idle_inputs();
      repeat (4) step();

      // Backpressure on the first record.
      bus.out_ready = 1'b0;
      set_snapshot(4'b0111, 64'd200);
      step();
      idle_inputs();
      repeat (5) step();
      bus.out_ready = 1'b1;
      repeat (5) step();

      // Fill past capacity with everything stalled.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_snapshot(4'b1111, 64'(300 + i));
         step();
      end
      idle_inputs();
      repeat (2) step();
      bus.out_ready = 1'b1;
      repeat (20) step();

      // Empty snapshots push nothing.
      bus.in_cycle = 64'd400;
      bus.in_valid = '0;
      repeat (3) step();

      random_phase(400, -1);

      // Reset with three snapshots buffered, then a fresh single snapshot.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_snapshot(4'b1101, 64'(450 + i));
         step();
      end
      idle_inputs();
      step();
      pulse_reset();
      step();
      bus.out_ready = 1'b1;
      set_snapshot(4'b1010, 64'd100);
      step();
      idle_inputs();
      repeat (4) step();

      // Finish together with a snapshot; later snapshots are refused.
      set_snapshot(4'b0001, 64'd500);
      bus.in_finished = 1'b1;
      step();
      idle_inputs();
      repeat (4) step();
      set_snapshot(4'b1111, 64'd600);
      repeat (2) step();
      idle_inputs();
      repeat (2) step();

      // Randomized traffic with a finish partway through.
      pulse_reset();
      random_phase(120, 70);

      check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
